// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
`timescale 1ns/1ps

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             busy_d;
  logic             done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_d;
`endif

  // Shared single-bit full adder on the operand LSBs and the carry flop.
  logic fa_s;
  logic fa_c;
  logic last_bit;

  assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum     <= sum_d;
      cout    <= cout_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= ovf_d;
`endif
    end
  end

  // Next-state and next-value logic; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum;
    cout_d  = cout;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule
